truth_table_sequencer: RTL

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_pkg.sv | 14 +
 rtl/settle_counter.sv | 42 ++++
 rtl/truth_table_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and limits for the truth-table sequencer.
//   state_t    : sequencer FSM states (IDLE, RUN, DONE)
//   MAX_INPUTS : largest supported NUM_INPUTS
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MAX_INPUTS = 6;

endpackage

// File: rtl/settle_counter.sv
// Settle counter: counts the cycles the current vector has been applied.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   clr   - synchronous clear (start of a new sweep)
//   en    - count enable (asserted while sweeping)
//   tick  - high on the last settle cycle of the current vector
module settle_counter #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  assign tick = en && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps every input vector of a gate under test,
// holds each for SETTLE_CYCLES cycles, samples the gate response on the last
// settle cycle and compares it against a golden truth table.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - one-cycle pulse requesting a sweep (ignored while busy)
//   expected   - golden output, bit i for input vector i
//   gate_in    - vector driven to the gate under test
//   gate_out   - gate response
//   busy       - sweep in progress
//   done       - sweep complete, held until next accepted start or reset
//   pass       - all samples matched (valid while done)
//   fail_index - first mismatching vector (valid while done and !pass)
//   captured   - sampled gate_out per vector index
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter int unsigned NUM_INPUTS    = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [(1<<NUM_INPUTS)-1:0]   expected,
  output logic [NUM_INPUTS-1:0]        gate_in,
  input  logic                         gate_out,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [NUM_INPUTS-1:0]        fail_index,
  output logic [(1<<NUM_INPUTS)-1:0]   captured
);

  localparam int unsigned          NVEC     = 1 << NUM_INPUTS;
  localparam logic [NUM_INPUTS:0]  LAST_VEC = (NUM_INPUTS + 1)'(NVEC - 1);
  localparam logic [NUM_INPUTS:0]  VEC_ONE  = (NUM_INPUTS + 1)'(1);

  state_t                  state_q, state_d;
  logic [NUM_INPUTS:0]     vec_q, vec_d;
  logic [NVEC-1:0]         captured_q, captured_d;
  logic                    mismatch_q, mismatch_d;
  logic [NUM_INPUTS-1:0]   fail_q, fail_d;
  logic [NUM_INPUTS-1:0]   gate_in_q, gate_in_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    cnt_clr, cnt_en, tick;
  logic [NUM_INPUTS-1:0]   vec_idx;

  assign vec_idx = vec_q[NUM_INPUTS-1:0];

  settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    captured_d = captured_q;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          vec_d      = '0;
          captured_d = '0;
          mismatch_d = 1'b0;
          fail_d     = '0;
          cnt_clr    = 1'b1;
        end
      end
      RUN: begin
        cnt_en = 1'b1;
        if (tick) begin
          captured_d[vec_idx] = gate_out;
          // Only the first mismatch is recorded.
          if ((gate_out != expected[vec_idx]) && !mismatch_q) begin
            mismatch_d = 1'b1;
            fail_d     = vec_idx;
          end
          vec_d = vec_q + VEC_ONE;
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with
    // the state register while keeping gate_out off any output path.
    unique case (state_d)
      RUN:     gate_in_d = vec_d[NUM_INPUTS-1:0];
      DONE:    gate_in_d = gate_in_q;
      default: gate_in_d = '0;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && !mismatch_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      captured_q <= '0;
      mismatch_q <= 1'b0;
      fail_q     <= '0;
      gate_in_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      captured_q <= captured_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
      gate_in_q  <= gate_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign gate_in    = gate_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_index = fail_q;
  assign captured   = captured_q;

endmodule
